// File: rtl/watch_pkg.sv
// Shared types and constants for the watch display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high, for common-cathode digits.
package watch_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // IDLE: display dark; BLANK: ghosting dead-time; ON: digit driven
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder. Codes 10-15 produce a blank digit.
module bcd_to_7seg
    import watch_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    // Pure lookup; non-decimal codes blank the digit rather than show hex glyphs
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/watch_display_scan.sv
// Time-multiplexed 7-segment scan scheduler for the watch display.
// Each digit owns the shared segment bus for SCAN_DIV cycles per frame: the
// first DEAD_CYC cycles are blanked to stop ghosting, the rest are driven with
// the digit enable gated by a free-running PWM comparison against brightness_i.
// New time values are held pending and swapped in only at frame boundaries.
// Optional feature macro: WATCH_BLINK_EN adds blink_mask_i and a blink phase
// that darkens masked digits on alternate BLINK_FRAMES-frame periods.
module watch_display_scan
    import watch_pkg::*;
#(
    parameter int                    NUM_DIGITS = 6,
    parameter int                    SCAN_DIV   = 1000,
    parameter int                    DEAD_CYC   = 4,
    parameter int                    DUTY_W     = 4,
    parameter logic [NUM_DIGITS-1:0] DP_MASK    = 6'b010100
`ifdef WATCH_BLINK_EN
    ,
    parameter int                    BLINK_FRAMES = 64
`endif
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
    input  logic                      load_i,
    input  logic [DUTY_W-1:0]         brightness_i,
`ifdef WATCH_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask_i,
`endif
    output logic [SEG_W-1:0]          seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     dig_sel_o,
    output logic                      frame_done_o
);

    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] DEAD_LAST = SLOT_W'(DEAD_CYC - 1);

    scan_state_t                 state_reg, state_next;
    logic [DIG_W-1:0]            digit_idx_reg, digit_idx_next;
    logic [SLOT_W-1:0]           slot_cnt_reg, slot_cnt_next;
    logic [DUTY_W-1:0]           pwm_cnt_reg;
    logic [BCD_W*NUM_DIGITS-1:0] shadow_reg;
    logic [BCD_W*NUM_DIGITS-1:0] pending_reg;
    logic                        pending_flag_reg;

    logic                        frame_end;
    logic                        scan_start;
    logic                        pwm_on;
    logic                        digit_dark;
    logic [NUM_DIGITS-1:0]       sel_hit;
    logic [BCD_W-1:0]            cur_bcd;
    logic                        cur_dp;
    logic [SEG_W-1:0]            cur_seg;

    logic [SEG_W-1:0]            seg_next;
    logic                        dp_next;
    logic [NUM_DIGITS-1:0]       dig_sel_next;

    // One-hot decode of the active digit index
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign sel_hit[gi] = (digit_idx_reg == DIG_W'(gi));
        end
    endgenerate

    // Pick the active digit's BCD code and decimal-point bit
    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_hit[i]) begin
                cur_bcd = shadow_reg[i*BCD_W +: BCD_W];
                cur_dp  = DP_MASK[i];
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // Full scale is forced on so the all-ones code never leaves a dark PWM step
    assign pwm_on = (&brightness_i) || (pwm_cnt_reg < brightness_i);

`ifdef WATCH_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    // Count frame ends; flip the blink phase every BLINK_FRAMES frames
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign digit_dark = blink_phase_reg && |(sel_hit & blink_mask_i);
`else
    assign digit_dark = 1'b0;
`endif

    // Scan FSM next-state plus the next values of the registered pad outputs
    always_comb begin
        state_next     = state_reg;
        digit_idx_next = digit_idx_reg;
        slot_cnt_next  = slot_cnt_reg;
        frame_end      = 1'b0;
        scan_start     = 1'b0;
        seg_next       = '0;
        dp_next        = 1'b0;
        dig_sel_next   = '0;

        case (state_reg)
            IDLE: begin
                if (enable_i) begin
                    state_next     = BLANK;
                    digit_idx_next = '0;
                    slot_cnt_next  = '0;
                    scan_start     = 1'b1;
                end
            end
            BLANK: begin
                slot_cnt_next = slot_cnt_reg + 1'b1;
                if (slot_cnt_reg == DEAD_LAST) begin
                    state_next = ON;
                end
            end
            ON: begin
                seg_next = cur_seg;
                dp_next  = cur_dp;
                if (pwm_on && !digit_dark) begin
                    dig_sel_next = sel_hit;
                end
                if (slot_cnt_reg == SLOT_LAST) begin
                    slot_cnt_next = '0;
                    state_next    = BLANK;
                    if (digit_idx_reg == DIG_LAST) begin
                        digit_idx_next = '0;
                        frame_end      = 1'b1;
                    end else begin
                        digit_idx_next = digit_idx_reg + 1'b1;
                    end
                end else begin
                    slot_cnt_next = slot_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Disable wins over everything: go dark next cycle, no frame pulse
        if (!enable_i) begin
            state_next     = IDLE;
            digit_idx_next = '0;
            slot_cnt_next  = '0;
            frame_end      = 1'b0;
            scan_start     = 1'b0;
            seg_next       = '0;
            dp_next        = 1'b0;
            dig_sel_next   = '0;
        end
    end

    // Scan state, slot/digit counters and the free-running PWM counter
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            digit_idx_reg <= '0;
            slot_cnt_reg  <= '0;
            pwm_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            digit_idx_reg <= digit_idx_next;
            slot_cnt_reg  <= slot_cnt_next;
            pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
        end
    end

    // Double buffer: loads land in pending; shadow only changes at frame
    // start/end so a digit never changes mid-frame. A load coincident with
    // the swap is kept pending for the following frame.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg       <= '0;
            pending_reg      <= '0;
            pending_flag_reg <= 1'b0;
        end else begin
            if ((frame_end || scan_start) && pending_flag_reg) begin
                shadow_reg <= pending_reg;
            end
            if (load_i) begin
                pending_reg      <= digits_i;
                pending_flag_reg <= 1'b1;
            end else if (frame_end || scan_start) begin
                pending_flag_reg <= 1'b0;
            end
        end
    end

    // Registered pad outputs, one cycle behind the internal scan state
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            seg_o        <= '0;
            dp_o         <= 1'b0;
            dig_sel_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            seg_o        <= seg_next;
            dp_o         <= dp_next;
            dig_sel_o    <= dig_sel_next;
            frame_done_o <= frame_end;
        end
    end

endmodule

// File: tb/tb_watch_display_scan.sv
// Directed self-checking bench for watch_display_scan with a short scan
// (6 digits, 8-cycle slots, 2 dead cycles, 4-bit brightness).
module tb_watch_display_scan;
    import watch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [23:0] digits;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  sel;
    logic        fd;
    logic [5:0]  bmask;

    // Expected segment pattern per digit position for the shown value
    logic [6:0]  tab [6];
    logic [5:0]  dpm = 6'b010100;
    int          c;
    int          pcount;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    watch_display_scan #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (8),
        .DEAD_CYC   (2),
        .DUTY_W     (4),
        .DP_MASK    (6'b010100)
`ifdef WATCH_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .wb_clk_i     (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .digits_i     (digits),
        .load_i       (load),
        .brightness_i (bright),
`ifdef WATCH_BLINK_EN
        .blink_mask_i (bmask),
`endif
        .seg_o        (seg),
        .dp_o         (dp),
        .dig_sel_o    (sel),
        .frame_done_o (fd)
    );

    // Clock edges seen since the last reset; the DUT PWM counter tracks this
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcount <= 0;
        else        pcount <= pcount + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] outs();
        return {17'b0, seg, dp, sel, fd};
    endfunction

    // Expected pads for frame position cc: digit cc/8, slot cc%8
    function automatic logic [31:0] expect_out(input int cc);
        int         d  = (cc / 8) % 6;
        int         s  = cc % 8;
        logic [3:0] pw = 4'(pcount - 1);
        logic [6:0] sg = 7'h00;
        logic       p  = 1'b0;
        logic [5:0] sl = 6'b0;
        logic       f;
        logic       hide = 1'b0;
`ifdef WATCH_BLINK_EN
        hide = bmask[d] && (((cc / 48) / 2) % 2 == 1);
`endif
        f = (d == 5) && (s == 7);
        if (s >= 2) begin
            sg = tab[d];
            p  = dpm[d];
            if (((bright == 4'hF) || (pw < bright)) && !hide) sl = 6'(1 << d);
        end
        return {17'b0, sg, p, sl, f};
    endfunction

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s[c=%0d]", tag, c), outs(), expect_out(c));
            c++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        digits = '0;
        bright = '0;
        bmask  = '0;
        c      = 0;
        tab    = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

        // 1. reset, then idle with enable low
        repeat (3) @(negedge clk);
        check("reset_hold", outs(), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_dark", outs(), 32'h0);
        end

        // 2. load 123456 while idle, then start scanning at full brightness
        digits = 24'h123456; load = 1'b1; bright = 4'hF;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
        @(negedge clk);
        check("start_from_idle", outs(), 32'h0);
        tab = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        c = 0;
        run(96, "t2_full");

        // 3. brightness 0 then 8
        bright = 4'h0;
        run(96, "t3_dark");
        bright = 4'h8;
        run(768, "t3_pwm8");

        // 4. mid-frame load of 000000: old digits until frame end
        bright = 4'hF;
        run(20, "t4_pre");
        digits = 24'h000000; load = 1'b1;
        run(1, "t4_load");
        load = 1'b0;
        run(27, "t4_old");
        tab = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        run(10, "t4_zero");
        digits = 24'h111111; load = 1'b1;
        run(1, "t4_zero");
        load = 1'b0;
        run(10, "t4_zero");
        digits = 24'h987654; load = 1'b1;
        run(1, "t4_zero");
        load = 1'b0;
        run(26, "t4_zero");
        tab = '{7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        // load coincident with frame end waits one more frame
        run(47, "t4_last");
        digits = 24'h1F2A3C; load = 1'b1;
        run(1, "t4_last");
        load = 1'b0;
        run(48, "t4_held");

        // 5. non-decimal codes blank segments but keep dp
        tab = '{7'h00, 7'h4F, 7'h00, 7'h5B, 7'h00, 7'h06};
        run(48, "t5_hex");

        // 6a. load then drop enable mid-ON; pending survives the restart
        run(10, "t6_pre");
        digits = 24'h222222; load = 1'b1;
        run(1, "t6_pre");
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_disabled", outs(), 32'h0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("t6_reenable", outs(), 32'h0);
        tab = '{7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B};
        c = 0;
        run(68, "t6_resume");

        // 6b. async reset mid-ON slot clears at once and restarts from digit 0
        rst_n = 1'b0;
        bmask = 6'b000011;
        #1;
        check("t6_rst_async", outs(), 32'h0);
        @(negedge clk);
        check("t6_rst_held", outs(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_idle", outs(), 32'h0);
        tab = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        c = 0;
        run(288, "t6_restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
